// File: rtl/aes_fu_pkg.sv
// Shared definitions for the AES functional-unit arbiter: FSM encoding,
// parameter defaults and width helpers.
package aes_fu_pkg;

  localparam int unsigned NREQ_DEFAULT    = 2;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } fu_state_t;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping at N.
module aes_rr_pick
  import aes_fu_pkg::*;
#(
  parameter int unsigned N  = NREQ_DEFAULT,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/aes_fu_arbiter.sv
// Round-robin arbiter sharing one AES functional unit between NREQ requesters;
// operands latched at grant, one operation outstanding, result held until accepted.
module aes_fu_arbiter
  import aes_fu_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_dec,
  input  logic [NREQ-1:0]    req_mix,
  input  logic [32*NREQ-1:0] req_rs1,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_rd,
  output logic               rsp_err,
  output logic               fu_valid,
  output logic               fu_dec,
  output logic               fu_mix,
  output logic [31:0]        fu_rs1,
  input  logic               fu_ready,
  input  logic [31:0]        fu_rd
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned CW = cnt_width(TIMEOUT);

  fu_state_t       state_q, state_d;
  logic [IW-1:0]   ptr_q, owner_q;
  logic            dec_q, mix_q, err_q;
  logic [31:0]     rs1_q, rd_q;
  logic [CW-1:0]   cnt_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            grant;
  logic            owner_ack;
  logic            cnt_last;
  logic [NREQ-1:0] owner_oh;

  aes_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Qualifying with g_resetn keeps req_ready low while reset is held, even
  // though the state register already reads IDLE.
  assign grant     = (state_q == ST_IDLE) && g_resetn && pick_any;
  assign owner_ack = rsp_ready[owner_q];
  assign cnt_last  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: if (fu_ready || cnt_last) state_d = ST_RESP;
      ST_RESP:  if (owner_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      ptr_q   <= '0;
      owner_q <= '0;
      dec_q   <= 1'b0;
      mix_q   <= 1'b0;
      rs1_q   <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (grant) begin
      owner_q <= pick_idx;
      dec_q   <= req_dec[pick_idx];
      mix_q   <= req_mix[pick_idx];
      rs1_q   <= req_rs1[32*pick_idx +: 32];
      cnt_q   <= '0;
      ptr_q   <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
    end else if (state_q == ST_ISSUE) begin
      if (fu_ready) begin
        rd_q  <= fu_rd;
        err_q <= 1'b0;
      end else if (cnt_last) begin
        rd_q  <= '0;
        err_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign req_ready = grant ? pick_gnt : '0;
  assign rsp_valid = (state_q == ST_RESP) ? owner_oh : '0;
  assign rsp_rd    = rd_q;
  assign rsp_err   = err_q;
  assign fu_valid  = (state_q == ST_ISSUE);
  assign fu_dec    = dec_q;
  assign fu_mix    = mix_q;
  assign fu_rs1    = rs1_q;

endmodule
